// File: rtl/coin_collector_if.sv
// Coin collector bus: coin touch inputs, frame/restart strobes, collection and sparkle status.
interface coin_collector_if #(
    parameter int unsigned NUM_COINS = 8
);
    localparam int unsigned IDX_W = (NUM_COINS > 1) ? $clog2(NUM_COINS) : 1;

    logic [NUM_COINS-1:0] touch;
    logic                 frame_tick;
    logic                 level_restart;

    logic [NUM_COINS-1:0] collected;
    logic [3:0]           coin_ones;
    logic [3:0]           coin_tens;
    logic                 collect_pulse;
    logic                 one_up;
    logic                 sparkle_active;
    logic [IDX_W-1:0]     sparkle_idx;
    logic [3:0]           sparkle_frame;

    // Game logic side: drives touches and strobes, observes collection state.
    modport master (
        output touch,
        output frame_tick,
        output level_restart,
        input  collected,
        input  coin_ones,
        input  coin_tens,
        input  collect_pulse,
        input  one_up,
        input  sparkle_active,
        input  sparkle_idx,
        input  sparkle_frame
    );

    // Collector side.
    modport slave (
        input  touch,
        input  frame_tick,
        input  level_restart,
        output collected,
        output coin_ones,
        output coin_tens,
        output collect_pulse,
        output one_up,
        output sparkle_active,
        output sparkle_idx,
        output sparkle_frame
    );
endinterface

// File: rtl/coin_collector.sv
// Coin collector: latches coin touch edges, collects one coin every two cycles,
// keeps a two-digit BCD coin count and runs a per-coin sparkle animation.
module coin_collector #(
    parameter int unsigned NUM_COINS      = 8,
    parameter int unsigned SPARKLE_FRAMES = 12
) (
    input  logic            clk,
    input  logic            reset,
    coin_collector_if.slave bus
);
    localparam int unsigned IDX_W      = (NUM_COINS > 1) ? $clog2(NUM_COINS) : 1;
    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned FRAME_W    = 4;
    localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(SPARKLE_FRAMES - 1);
    localparam logic [DIGIT_W-1:0] DIGIT_MAX  = DIGIT_W'(9);

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_COLLECT = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [NUM_COINS-1:0] touch_prev_q, touch_prev_d;
    logic [NUM_COINS-1:0] pending_q, pending_d;
    logic [NUM_COINS-1:0] collected_q, collected_d;
    logic [IDX_W-1:0]     sel_q, sel_d;
    logic [DIGIT_W-1:0]   ones_q, ones_d;
    logic [DIGIT_W-1:0]   tens_q, tens_d;
    logic                 collect_pulse_q, collect_pulse_d;
    logic                 one_up_q, one_up_d;
    logic                 sparkle_active_q, sparkle_active_d;
    logic [IDX_W-1:0]     sparkle_idx_q, sparkle_idx_d;
    logic [FRAME_W-1:0]   sparkle_frame_q, sparkle_frame_d;

    logic [NUM_COINS-1:0] rise_c;
    logic [NUM_COINS-1:0] sel_mask_c;
    logic [IDX_W-1:0]     lowest_c;
    logic                 any_pending_c;
    logic                 collect_fire_c;

    // Rising-edge detect on uncollected coins; restart wipes the edge history.
    always_comb begin
        rise_c       = bus.touch & ~touch_prev_q & ~collected_q;
        touch_prev_d = bus.level_restart ? '0 : bus.touch;
    end

    // Lowest-index pending coin wins the next collect slot.
    always_comb begin
        logic found;
        found         = 1'b0;
        lowest_c      = '0;
        any_pending_c = |pending_q;
        for (int unsigned i = 0; i < NUM_COINS; i++) begin
            if (pending_q[i] && !found) begin
                lowest_c = IDX_W'(i);
                found    = 1'b1;
            end
        end
    end

    // Next-state logic: IDLE picks a coin, COLLECT retires it in one cycle.
    always_comb begin
        state_d        = state_q;
        sel_d          = sel_q;
        collect_fire_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (any_pending_c) begin
                    state_d = S_COLLECT;
                    sel_d   = lowest_c;
                end
            end
            S_COLLECT: begin
                collect_fire_c = 1'b1;
                state_d        = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (bus.level_restart) begin
            state_d = S_IDLE;
        end
    end

    // One-hot mask of the coin being retired this cycle.
    always_comb begin
        sel_mask_c = '0;
        for (int unsigned i = 0; i < NUM_COINS; i++) begin
            sel_mask_c[i] = collect_fire_c && (sel_q == IDX_W'(i));
        end
    end

    // Pending/collected bookkeeping; restart clears both even during a collect.
    always_comb begin
        pending_d   = (pending_q | rise_c) & ~sel_mask_c;
        collected_d = collected_q | sel_mask_c;
        if (bus.level_restart) begin
            pending_d   = '0;
            collected_d = '0;
        end
    end

    // BCD coin count with 99 -> 00 wrap raising one_up; restart never blocks it.
    always_comb begin
        ones_d          = ones_q;
        tens_d          = tens_q;
        one_up_d        = 1'b0;
        collect_pulse_d = collect_fire_c;
        if (collect_fire_c) begin
            if (ones_q == DIGIT_MAX) begin
                ones_d = '0;
                if (tens_q == DIGIT_MAX) begin
                    tens_d   = '0;
                    one_up_d = 1'b1;
                end else begin
                    tens_d = tens_q + DIGIT_W'(1);
                end
            end else begin
                ones_d = ones_q + DIGIT_W'(1);
            end
        end
    end

    // Sparkle animation: a new collect restarts it, frame ticks advance it.
    always_comb begin
        sparkle_active_d = sparkle_active_q;
        sparkle_idx_d    = sparkle_idx_q;
        sparkle_frame_d  = sparkle_frame_q;
        if (bus.level_restart) begin
            sparkle_active_d = 1'b0;
            sparkle_idx_d    = '0;
            sparkle_frame_d  = '0;
        end else if (collect_fire_c) begin
            sparkle_active_d = 1'b1;
            sparkle_idx_d    = sel_q;
            sparkle_frame_d  = '0;
        end else if (sparkle_active_q && bus.frame_tick) begin
            if (sparkle_frame_q == LAST_FRAME) begin
                sparkle_active_d = 1'b0;
                sparkle_frame_d  = '0;
            end else begin
                sparkle_frame_d = sparkle_frame_q + FRAME_W'(1);
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_IDLE;
            touch_prev_q     <= '0;
            pending_q        <= '0;
            collected_q      <= '0;
            sel_q            <= '0;
            ones_q           <= '0;
            tens_q           <= '0;
            collect_pulse_q  <= 1'b0;
            one_up_q         <= 1'b0;
            sparkle_active_q <= 1'b0;
            sparkle_idx_q    <= '0;
            sparkle_frame_q  <= '0;
        end else begin
            state_q          <= state_d;
            touch_prev_q     <= touch_prev_d;
            pending_q        <= pending_d;
            collected_q      <= collected_d;
            sel_q            <= sel_d;
            ones_q           <= ones_d;
            tens_q           <= tens_d;
            collect_pulse_q  <= collect_pulse_d;
            one_up_q         <= one_up_d;
            sparkle_active_q <= sparkle_active_d;
            sparkle_idx_q    <= sparkle_idx_d;
            sparkle_frame_q  <= sparkle_frame_d;
        end
    end

    assign bus.collected      = collected_q;
    assign bus.coin_ones      = ones_q;
    assign bus.coin_tens      = tens_q;
    assign bus.collect_pulse  = collect_pulse_q;
    assign bus.one_up         = one_up_q;
    assign bus.sparkle_active = sparkle_active_q;
    assign bus.sparkle_idx    = sparkle_idx_q;
    assign bus.sparkle_frame  = sparkle_frame_q;

endmodule

// File: tb/tb_coin_collector.sv
// Bench for coin_collector: directed scenarios plus random traffic, all outputs
// compared every cycle against a behavioural model of the collector.
module tb_coin_collector;
    localparam int unsigned N  = 8;
    localparam int unsigned SF = 12;

    logic clk = 1'b0;
    logic reset;

    coin_collector_if #(.NUM_COINS(N)) bif ();

    coin_collector #(
        .NUM_COINS     (N),
        .SPARKLE_FRAMES(SF)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bif)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int n_oneup = 0;
    int pulse_at[$];

    // Behavioural model state: sets of coins, integer count, integer frame.
    logic [N-1:0] m_prev = '0;
    logic [N-1:0] m_pend = '0;
    logic [N-1:0] m_coll = '0;
    bit m_busy   = 1'b0;
    int m_sel    = 0;
    int m_count  = 0;
    bit m_pulse  = 1'b0;
    bit m_oneup  = 1'b0;
    bit m_sp_on  = 1'b0;
    int m_sp_idx = 0;
    int m_sp_frame = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic [N-1:0] t, input bit ft, input bit lr, input bit rs);
        logic [N-1:0] old_pend;
        if (rs) begin
            m_prev = '0; m_pend = '0; m_coll = '0; m_busy = 1'b0; m_sel = 0;
            m_count = 0; m_pulse = 1'b0; m_oneup = 1'b0;
            m_sp_on = 1'b0; m_sp_idx = 0; m_sp_frame = 0;
            return;
        end
        old_pend = m_pend;
        m_pulse  = m_busy;
        m_oneup  = m_busy && (m_count == 99);
        if (m_busy) m_count = (m_count + 1) % 100;
        if (lr) begin
            m_prev = '0; m_pend = '0; m_coll = '0; m_busy = 1'b0;
            m_sp_on = 1'b0; m_sp_idx = 0; m_sp_frame = 0;
            return;
        end
        for (int i = 0; i < int'(N); i++) begin
            if (t[i] && !m_prev[i] && !m_coll[i]) m_pend[i] = 1'b1;
        end
        m_prev = t;
        if (m_busy) begin
            m_coll[m_sel] = 1'b1;
            m_pend[m_sel] = 1'b0;
            m_sp_on = 1'b1; m_sp_idx = m_sel; m_sp_frame = 0;
            m_busy = 1'b0;
        end else begin
            if (ft && m_sp_on) begin
                if (m_sp_frame == int'(SF) - 1) begin
                    m_sp_on = 1'b0; m_sp_frame = 0;
                end else begin
                    m_sp_frame = m_sp_frame + 1;
                end
            end
            if (old_pend != '0) begin
                m_busy = 1'b1;
                m_sel  = 0;
                for (int i = int'(N) - 1; i >= 0; i--) begin
                    if (old_pend[i]) m_sel = i;
                end
            end
        end
    endtask

    // One clock: drive inputs, advance the model, then compare every output.
    task automatic step(input logic [N-1:0] t, input bit ft, input bit lr, input bit rs);
        bif.touch = t; bif.frame_tick = ft; bif.level_restart = lr; reset = rs;
        @(posedge clk);
        model_step(t, ft, lr, rs);
        #1;
        chk("collected",      32'(bif.collected),      32'(m_coll));
        chk("coin_ones",      32'(bif.coin_ones),      32'(m_count % 10));
        chk("coin_tens",      32'(bif.coin_tens),      32'(m_count / 10));
        chk("collect_pulse",  32'(bif.collect_pulse),  32'(m_pulse));
        chk("one_up",         32'(bif.one_up),         32'(m_oneup));
        chk("sparkle_active", 32'(bif.sparkle_active), 32'(m_sp_on));
        chk("sparkle_idx",    32'(bif.sparkle_idx),    32'(m_sp_idx));
        chk("sparkle_frame",  32'(bif.sparkle_frame),  32'(m_sp_frame));
        if (bif.collect_pulse === 1'b1) pulse_at.push_back(cyc);
        if (bif.one_up === 1'b1) n_oneup++;
        cyc++;
    endtask

    initial begin
        int base;
        int first;
        int second;
        bit seen;
        logic [N-1:0] t;
        bit ft;
        bit lr;
        bit rs;

        bif.touch = '0; bif.frame_tick = 1'b0; bif.level_restart = 1'b0; reset = 1'b1;

        // Reset state
        step('0, 0, 0, 1);
        step('0, 0, 0, 1);
        chk("rst_collected", 32'(bif.collected), 32'h0);
        chk("rst_ones", 32'(bif.coin_ones), 32'h0);
        chk("rst_tens", 32'(bif.coin_tens), 32'h0);
        chk("rst_sparkle", 32'(bif.sparkle_active), 32'h0);

        // Held touch on coin 3 collects exactly once, two cycles after the edge
        step('0, 0, 0, 0);
        pulse_at.delete();
        base = cyc;
        for (int k = 0; k < 10; k++) step(8'h08, 0, 0, 0);
        step('0, 0, 0, 0);
        step('0, 0, 0, 0);
        first = (pulse_at.size() > 0) ? pulse_at[0] - base : -1;
        chk("held_npulse", 32'(pulse_at.size()), 32'd1);
        chk("held_at", 32'(first), 32'd2);
        chk("held_collected", 32'(bif.collected), 32'h08);
        chk("held_ones", 32'(bif.coin_ones), 32'd1);
        chk("held_tens", 32'(bif.coin_tens), 32'd0);

        // Two coins rising together are collected two cycles apart
        step('0, 0, 0, 1);
        pulse_at.delete();
        base = cyc;
        step(8'h05, 0, 0, 0);
        for (int k = 0; k < 6; k++) step('0, 0, 0, 0);
        first  = (pulse_at.size() > 0) ? pulse_at[0] - base : -1;
        second = (pulse_at.size() > 1) ? pulse_at[1] - base : -1;
        chk("pair_npulse", 32'(pulse_at.size()), 32'd2);
        chk("pair_first", 32'(first), 32'd2);
        chk("pair_second", 32'(second), 32'd4);
        chk("pair_ones", 32'(bif.coin_ones), 32'd2);
        chk("pair_collected", 32'(bif.collected), 32'h05);
        chk("pair_sparkle_idx", 32'(bif.sparkle_idx), 32'd2);

        // Full sparkle run over SF frame ticks
        step('0, 0, 0, 1);
        step(8'h02, 0, 0, 0);
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            step('0, 0, 0, 0);
            if (bif.collect_pulse === 1'b1) seen = 1'b1;
        end
        chk("spark_seen", 32'(seen), 32'd1);
        chk("spark_start_frame", 32'(bif.sparkle_frame), 32'd0);
        chk("spark_start_idx", 32'(bif.sparkle_idx), 32'd1);
        for (int j = 1; j <= int'(SF); j++) begin
            step('0, 1, 0, 0);
            if (j < int'(SF)) begin
                chk("spark_frame", 32'(bif.sparkle_frame), 32'(j));
                chk("spark_on", 32'(bif.sparkle_active), 32'd1);
            end else begin
                chk("spark_end_active", 32'(bif.sparkle_active), 32'd0);
                chk("spark_end_frame", 32'(bif.sparkle_frame), 32'd0);
            end
        end

        // Restart keeps the count and re-arms coins
        step('0, 0, 0, 1);
        step(8'h07, 0, 0, 0);
        for (int k = 0; k < 8; k++) step('0, 0, 0, 0);
        chk("rearm_ones3", 32'(bif.coin_ones), 32'd3);
        chk("rearm_coll7", 32'(bif.collected), 32'h07);
        step('0, 0, 1, 0);
        chk("rearm_cleared", 32'(bif.collected), 32'h00);
        chk("rearm_kept", 32'(bif.coin_ones), 32'd3);
        step(8'h01, 0, 0, 0);
        for (int k = 0; k < 3; k++) step('0, 0, 0, 0);
        chk("rearm_ones4", 32'(bif.coin_ones), 32'd4);
        chk("rearm_coll1", 32'(bif.collected), 32'h01);

        // Count wrap 99 -> 00 with one_up alongside collect_pulse
        step('0, 0, 0, 1);
        n_oneup = 0;
        for (int k = 0; k < 99; k++) begin
            step(8'h01, 0, 0, 0);
            step('0, 0, 0, 0);
            step('0, 0, 0, 0);
            step('0, 0, 1, 0);
        end
        chk("wrap_pre_ones", 32'(bif.coin_ones), 32'd9);
        chk("wrap_pre_tens", 32'(bif.coin_tens), 32'd9);
        chk("wrap_pre_oneup", 32'(n_oneup), 32'd0);
        step(8'h01, 0, 0, 0);
        step('0, 0, 0, 0);
        step('0, 0, 0, 0);
        chk("wrap_pulse", 32'(bif.collect_pulse), 32'd1);
        chk("wrap_oneup", 32'(bif.one_up), 32'd1);
        chk("wrap_ones", 32'(bif.coin_ones), 32'd0);
        chk("wrap_tens", 32'(bif.coin_tens), 32'd0);
        step('0, 0, 0, 0);
        chk("wrap_oneup_count", 32'(n_oneup), 32'd1);

        // Reset in the collect cycle discards the collection
        step('0, 0, 0, 1);
        step(8'h01, 0, 0, 0);
        step('0, 0, 0, 0);
        step('0, 0, 0, 1);
        chk("rstmid_pulse", 32'(bif.collect_pulse), 32'd0);
        chk("rstmid_coll", 32'(bif.collected), 32'h00);
        chk("rstmid_ones", 32'(bif.coin_ones), 32'd0);
        chk("rstmid_spark", 32'(bif.sparkle_active), 32'd0);

        // Restart coinciding with the collect cycle: count and pulse survive
        step('0, 0, 0, 1);
        step(8'h01, 0, 0, 0);
        step('0, 0, 0, 0);
        step('0, 0, 1, 0);
        chk("rstcol_pulse", 32'(bif.collect_pulse), 32'd1);
        chk("rstcol_coll", 32'(bif.collected), 32'h00);
        chk("rstcol_ones", 32'(bif.coin_ones), 32'd1);

        // Sparkle start beats a simultaneous frame tick
        step('0, 0, 0, 1);
        step(8'h10, 0, 0, 0);
        step('0, 0, 0, 0);
        step('0, 1, 0, 0);
        chk("tickstart_active", 32'(bif.sparkle_active), 32'd1);
        chk("tickstart_frame", 32'(bif.sparkle_frame), 32'd0);
        chk("tickstart_idx", 32'(bif.sparkle_idx), 32'd4);

        // Random traffic against the model
        t = '0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 2) == 0) t = N'($urandom & $urandom & $urandom);
            ft = ($urandom_range(0, 3) == 0);
            lr = ($urandom_range(0, 59) == 0);
            rs = ($urandom_range(0, 299) == 0);
            step(t, ft, lr, rs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
